// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state encoding and the
// conditional two's-complement negate used for operand magnitude and product sign fix-up.
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Widest product the helper can serve; callers size-cast the result down.
    localparam int unsigned MAX_PW = 128;

    function automatic logic [MAX_PW-1:0] cond_neg(input logic [MAX_PW-1:0] x,
                                                   input logic              neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Controller for seq_mult_hs: IDLE/CALC/DONE sequencing, iteration counter and the
// valid/ready handshake outputs.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic out_ready,
    input  logic rest_zero,
    output logic in_ready,
    output logic out_valid,
    output logic busy,
    output logic load,
    output logic calc,
    output logic finish
);

    state_t             state_q, state_d;
    logic   [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - 1'b1;
                // Early exit once no set multiplier bits remain after this step.
                if (rest_zero || (cnt_q == CNT_W'(1))) begin
                    finish  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign calc      = (state_q == S_CALC);

endmodule

// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier with valid/ready handshakes; operands are reduced to
// magnitudes at acceptance and the sign is reapplied to the product on completion.
module seq_mult_hs
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter bit          SIGN_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     sa,
    input  logic [WIDTH-1:0]     sb,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   tich,
    output logic                 busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [PW-1:0]    acc_q, mcand_q, tich_q;
    logic [WIDTH-1:0] mplier_q;
    logic             neg_q;

    logic             sgn;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [PW-1:0]    acc_n, prod;
    logic             load, calc, finish, rest_zero;

    assign sgn   = SIGN_EN && is_signed;
    assign abs_a = WIDTH'(cond_neg(MAX_PW'(sa), sgn & sa[WIDTH-1]));
    assign abs_b = WIDTH'(cond_neg(MAX_PW'(sb), sgn & sb[WIDTH-1]));

    assign acc_n     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod      = PW'(cond_neg(MAX_PW'(acc_n), neg_q));
    assign rest_zero = ((mplier_q >> 1) == '0);

    seq_mult_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .rest_zero (rest_zero),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .busy      (busy),
        .load      (load),
        .calc      (calc),
        .finish    (finish)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            tich_q   <= '0;
        end else if (load) begin
            mcand_q  <= PW'(abs_a);
            mplier_q <= abs_b;
            neg_q    <= sgn & (sa[WIDTH-1] ^ sb[WIDTH-1]);
            acc_q    <= '0;
            tich_q   <= '0;
        end else if (calc) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (finish) begin
                tich_q <= prod;
            end else begin
                acc_q  <= acc_n;
            end
        end
    end

    assign tich = tich_q;

endmodule
